// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 1 start bit, DATA_BITS data bits LSB first, 1 stop bit,
// no parity. Received words are presented on an AXI-Stream master port backed
// by a single holding register. Framing errors and overruns are one-cycle pulses.
//
// Handshake: a word transfers on any rising clk edge where m_axis_tvalid and
// m_axis_tready are both 1. m_axis_tvalid is registered, never depends on
// m_axis_tready combinationally, and m_axis_tdata holds steady while it is 1.
//
// Optional build macro: UART_RX_MAJORITY_VOTE_EN. When defined, every sample
// decision is a 2-of-3 vote over the synchronized line at the sample cycle and
// the two cycles before it. When undefined, the single synchronized value is used.
//
// o_dbg_state exposes the receiver FSM state: 0=IDLE 1=START 2=DATA 3=STOP.
module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 sreset,
    input  logic                 serial_data,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tvalid,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic                 framing_error,
    output logic                 overrun,
    output logic [1:0]           o_dbg_state
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] HALF_M1  = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_M1  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

    // Reject configurations the bit timing cannot support
    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_baud
            $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
        end
        if (DATA_BITS < 1 || DATA_BITS > 16) begin : g_bad_width
            $error("uart_rx: DATA_BITS must be in 1..16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                r_state;
    logic [BAUD_W-1:0]     r_baud_ctr;
    logic [BIT_W-1:0]      r_bit_ctr;
    logic [DATA_BITS-1:0]  r_shift;
    logic [1:0]            r_sync;
    logic                  r_rx_prev;
    logic                  w_rx_s;
    logic                  w_sample;
    logic [DATA_BITS-1:0]  w_shift_next;

    assign w_rx_s      = r_sync[1];
    assign o_dbg_state = r_state;

    // Two-flop synchronizer for the asynchronous line plus a one-cycle delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (sreset) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], serial_data};
            r_rx_prev <= w_rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    // History of rx_s: bit 0 is fed from the first sync flop so it always equals rx_s,
    // bits 1 and 2 are rx_s one and two cycles earlier; the decision timing is unchanged.
    logic [2:0] r_hist;

    // Shift the synchronized line into the 3-sample history
    always_ff @(posedge clk) begin
        if (sreset) begin
            r_hist <= 3'b111;
        end else begin
            r_hist <= {r_hist[1:0], r_sync[0]};
        end
    end

    assign w_sample = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
`else
    assign w_sample = w_rx_s;
`endif

    // Next shift-register value: right shift with the new sample entering at the MSB
    always_comb begin
        w_shift_next                = r_shift >> 1;
        w_shift_next[DATA_BITS-1]   = w_sample;
    end

    // Receiver FSM, holding register and flag pulses
    always_ff @(posedge clk) begin
        if (sreset) begin
            r_state       <= IDLE;
            r_baud_ctr    <= '0;
            r_bit_ctr     <= '0;
            r_shift       <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;

            // A handshake empties the holding register unless STOP reloads it below
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    // Only a 1->0 transition starts a frame, so a line stuck low is ignored
                    if (r_rx_prev && !w_rx_s) begin
                        r_state    <= START;
                        r_baud_ctr <= '0;
                    end
                end

                START: begin
                    if (r_baud_ctr == HALF_M1) begin
                        r_baud_ctr <= '0;
                        if (w_sample) begin
                            r_state <= IDLE;
                        end else begin
                            r_state   <= DATA;
                            r_bit_ctr <= '0;
                        end
                    end else begin
                        r_baud_ctr <= r_baud_ctr + BAUD_W'(1);
                    end
                end

                DATA: begin
                    if (r_baud_ctr == FULL_M1) begin
                        r_baud_ctr <= '0;
                        r_shift    <= w_shift_next;
                        r_bit_ctr  <= r_bit_ctr + BIT_W'(1);
                        if (r_bit_ctr == BIT_LAST) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_baud_ctr <= r_baud_ctr + BAUD_W'(1);
                    end
                end

                STOP: begin
                    if (r_baud_ctr == FULL_M1) begin
                        r_baud_ctr <= '0;
                        r_state    <= IDLE;
                        if (!w_sample) begin
                            framing_error <= 1'b1;
                        end else if (!m_axis_tvalid || m_axis_tready) begin
                            m_axis_tdata  <= r_shift;
                            m_axis_tvalid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        r_baud_ctr <= r_baud_ctr + BAUD_W'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 16 clocks per bit, 8 data bits.
// Inputs change 2 time units after a rising edge; outputs are observed on the
// falling edge. A monitor records handshakes, flag pulses and the tvalid rise.
module tb_uart_rx;

    logic       clk;
    logic       sreset;
    logic       serial_data;
    logic       m_axis_tready;
    logic       m_axis_tvalid;
    logic [7:0] m_axis_tdata;
    logic       framing_error;
    logic       overrun;
    logic [1:0] o_dbg_state;

    int checks   = 0;
    int failures = 0;

    int cyc       = 0;
    int start_cyc = 0;

    // Monitor-owned observations
    int         n_xfer   = 0;
    int         fe_cnt   = 0;
    int         ov_cnt   = 0;
    int         rise_cyc = 0;
    int         ov_cyc   = 0;
    logic       prev_v   = 1'b0;
    logic [7:0] got_mem [0:63];

    logic [7:0] exp_q [$];

    uart_rx #(
        .CLK_FREQ (1600),
        .BAUD_RATE(100),
        .DATA_BITS(8)
    ) dut (
        .clk          (clk),
        .sreset       (sreset),
        .serial_data  (serial_data),
        .m_axis_tready(m_axis_tready),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata (m_axis_tdata),
        .framing_error(framing_error),
        .overrun      (overrun),
        .o_dbg_state  (o_dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    // Monitor: handshakes, flags and tvalid rise time, sampled mid-cycle
    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            got_mem[n_xfer[5:0]] = m_axis_tdata;
            n_xfer = n_xfer + 1;
        end
        if (framing_error) fe_cnt = fe_cnt + 1;
        if (overrun) begin
            ov_cnt = ov_cnt + 1;
            ov_cyc = cyc;
        end
        if (m_axis_tvalid && !prev_v) rise_cyc = cyc;
        prev_v = m_axis_tvalid;
    end

    // Drive the first n_cyc cycles of a frame; optionally invert one cycle at each data-bit sample point
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic glitch, input int n_cyc);
        logic [9:0] bits;
        int slot;
        bits = {stop_bit, d, 1'b0};
        for (int c = 0; c < n_cyc; c++) begin
            @(posedge clk);
            #2;
            if (c == 0) start_cyc = cyc;
            slot = c / 16;
            serial_data = bits[slot] ^ (glitch && slot >= 1 && slot <= 8 && (c % 16) == 8);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            serial_data = 1'b1;
        end
    endtask

    task automatic test_reset;
        sreset = 1'b1;
        serial_data = 1'b1;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        checks++;
        if (m_axis_tdata !== 8'h00) begin failures++; $display("FAIL reset_tdata: got %h want 00", m_axis_tdata); end
        checks++;
        if (framing_error !== 1'b0 || overrun !== 1'b0) begin
            failures++; $display("FAIL reset_flags: got fe=%b ov=%b want 0 0", framing_error, overrun);
        end
        checks++;
        if (o_dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", o_dbg_state); end
        @(posedge clk);
        #2;
        sreset = 1'b0;
        idle(10);
    endtask

    task automatic test_single;
        int x0, f0, o0;
        x0 = n_xfer; f0 = fe_cnt; o0 = ov_cnt;
        m_axis_tready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, 160);
        idle(30);
        checks++;
        if (n_xfer - x0 !== 1) begin failures++; $display("FAIL single_count: got %0d want 1", n_xfer - x0); end
        checks++;
        if (got_mem[x0[5:0]] !== 8'hA5) begin failures++; $display("FAIL single_data: got %h want a5", got_mem[x0[5:0]]); end
        checks++;
        if (fe_cnt != f0 || ov_cnt != o0) begin
            failures++; $display("FAIL single_flags: got fe=%0d ov=%0d want 0 0", fe_cnt - f0, ov_cnt - o0);
        end
        // 2 sync cycles + 1 to see the edge (T0) + 8 + 9*16 to the stop sample = 155 from the drive cycle
        checks++;
        if (rise_cyc - start_cyc !== 155) begin
            failures++; $display("FAIL single_latency: got %0d want 155", rise_cyc - start_cyc);
        end
    endtask

    task automatic test_back_to_back;
        int x0, o0;
        x0 = n_xfer; o0 = ov_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        send_frame(8'h00, 1'b1, 1'b0, 160);
        send_frame(8'hFF, 1'b1, 1'b0, 160);
        send_frame(8'h3C, 1'b1, 1'b0, 160);
        idle(30);
        checks++;
        if (n_xfer - x0 !== 3) begin failures++; $display("FAIL b2b_count: got %0d want 3", n_xfer - x0); end
        for (int k = 0; k < 3; k++) begin
            logic [7:0] e;
            logic [5:0] idx;
            e = exp_q.pop_front();
            idx = 6'(x0 + k);
            checks++;
            if (got_mem[idx] !== e) begin failures++; $display("FAIL b2b_word%0d: got %h want %h", k, got_mem[idx], e); end
        end
        checks++;
        if (ov_cnt != o0) begin failures++; $display("FAIL b2b_overrun: got %0d want 0", ov_cnt - o0); end
    endtask

    task automatic test_false_start;
        int x0, f0;
        x0 = n_xfer; f0 = fe_cnt;
        repeat (4) begin
            @(posedge clk);
            #2;
            serial_data = 1'b0;
        end
        idle(30);
        checks++;
        if (n_xfer != x0 || m_axis_tvalid !== 1'b0) begin
            failures++; $display("FAIL false_start_tvalid: got xfers=%0d tvalid=%b want 0 0", n_xfer - x0, m_axis_tvalid);
        end
        checks++;
        if (fe_cnt != f0) begin failures++; $display("FAIL false_start_fe: got %0d want 0", fe_cnt - f0); end
        checks++;
        if (o_dbg_state !== 2'd0) begin failures++; $display("FAIL false_start_state: got %0d want 0", o_dbg_state); end
        send_frame(8'h5A, 1'b1, 1'b0, 160);
        idle(30);
        checks++;
        if (n_xfer - x0 !== 1 || got_mem[x0[5:0]] !== 8'h5A) begin
            failures++; $display("FAIL false_start_next: got n=%0d data=%h want 1 5a", n_xfer - x0, got_mem[x0[5:0]]);
        end
    endtask

    task automatic test_framing;
        int x0, f0;
        x0 = n_xfer; f0 = fe_cnt;
        send_frame(8'h81, 1'b0, 1'b0, 160);
        idle(32);
        checks++;
        if (fe_cnt - f0 !== 1) begin failures++; $display("FAIL framing_pulse: got %0d want 1", fe_cnt - f0); end
        checks++;
        if (n_xfer != x0 || m_axis_tvalid !== 1'b0) begin
            failures++; $display("FAIL framing_no_word: got xfers=%0d tvalid=%b want 0 0", n_xfer - x0, m_axis_tvalid);
        end
        send_frame(8'h42, 1'b1, 1'b0, 160);
        idle(30);
        checks++;
        if (n_xfer - x0 !== 1 || got_mem[x0[5:0]] !== 8'h42) begin
            failures++; $display("FAIL framing_next: got n=%0d data=%h want 1 42", n_xfer - x0, got_mem[x0[5:0]]);
        end
    endtask

    task automatic test_overrun;
        int x0, o0;
        x0 = n_xfer; o0 = ov_cnt;
        m_axis_tready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 160);
        send_frame(8'h22, 1'b1, 1'b0, 160);
        idle(20);
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h11) begin
            failures++; $display("FAIL overrun_hold: got tvalid=%b tdata=%h want 1 11", m_axis_tvalid, m_axis_tdata);
        end
        checks++;
        if (ov_cnt - o0 !== 1) begin failures++; $display("FAIL overrun_pulse: got %0d want 1", ov_cnt - o0); end
        checks++;
        if (ov_cyc - start_cyc !== 155) begin
            failures++; $display("FAIL overrun_time: got %0d want 155", ov_cyc - start_cyc);
        end
        checks++;
        if (n_xfer != x0) begin failures++; $display("FAIL overrun_no_xfer: got %0d want 0", n_xfer - x0); end
        @(posedge clk);
        #2;
        m_axis_tready = 1'b1;
        idle(5);
        @(negedge clk);
        checks++;
        if (n_xfer - x0 !== 1 || got_mem[x0[5:0]] !== 8'h11) begin
            failures++; $display("FAIL overrun_drain: got n=%0d data=%h want 1 11", n_xfer - x0, got_mem[x0[5:0]]);
        end
        checks++;
        if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL overrun_empty: got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_reset_mid;
        int x0;
        logic g;
`ifdef UART_RX_MAJORITY_VOTE_EN
        g = 1'b1;
`else
        g = 1'b0;
`endif
        m_axis_tready = 1'b0;
        send_frame(8'h33, 1'b1, 1'b0, 160);
        idle(10);
        // Start bit, data bits 0..2, then half of data bit 3
        send_frame(8'h99, 1'b1, 1'b0, 72);
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h33 || o_dbg_state !== 2'd2) begin
            failures++;
            $display("FAIL midreset_pre: got tvalid=%b tdata=%h state=%0d want 1 33 2", m_axis_tvalid, m_axis_tdata, o_dbg_state);
        end
        @(posedge clk);
        #2;
        sreset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00 || framing_error !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs: got tvalid=%b tdata=%h fe=%b ov=%b want 0 00 0 0",
                     m_axis_tvalid, m_axis_tdata, framing_error, overrun);
        end
        checks++;
        if (o_dbg_state !== 2'd0) begin failures++; $display("FAIL midreset_state: got %0d want 0", o_dbg_state); end
        @(posedge clk);
        #2;
        sreset = 1'b0;
        serial_data = 1'b1;
        m_axis_tready = 1'b1;
        x0 = n_xfer;
        idle(40);
        checks++;
        if (n_xfer != x0) begin failures++; $display("FAIL midreset_dropped: got %0d xfers want 0", n_xfer - x0); end
        send_frame(8'h66, 1'b1, g, 160);
        idle(30);
        checks++;
        if (n_xfer - x0 !== 1 || got_mem[x0[5:0]] !== 8'h66) begin
            failures++; $display("FAIL midreset_next: got n=%0d data=%h want 1 66", n_xfer - x0, got_mem[x0[5:0]]);
        end
    endtask

    initial begin
        sreset = 1'b1;
        serial_data = 1'b1;
        m_axis_tready = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_false_start();
        test_framing();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
